// File: rtl/stream_combiner_pkg.sv
// Shared definitions for the stream combiner: BURST mode strings and the
// helper that decodes them (anything other than "yes" means half-throughput).
package stream_pkg;

    localparam string BURST_YES = "yes";
    localparam string BURST_NO  = "no";

    function automatic bit is_burst(input string mode);
        return (mode == BURST_YES) && (mode != BURST_NO);
    endfunction

endpackage

// File: rtl/stream_combiner_slot.sv
// One-entry input buffer for a single lane of the stream combiner.
// Holds one beat until drained; in burst mode it can refill in the drain cycle.
module stream_slot
    import stream_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string BURST = BURST_YES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] q,
    output logic             ready
);

    localparam bit BURST_EN = is_burst(BURST);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             accept;

    always_comb begin
        // drain is only high while this slot is full, so it merely reopens it
        ready  = ~full_q | (BURST_EN & drain);
        accept = valid & ready;
        full_d = full_q;
        data_d = data_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d = 1'b1;
            data_d = data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign q    = data_q;

endmodule

// File: rtl/stream_combiner.sv
// Two-lane valid/ready join: emits {lane1, lane0} once both slots hold a beat.
// Define STREAM_COMBINER_ASSERT_EN to compile simulation-only protocol checkers.
module stream_combiner
    import stream_pkg::*;
#(
    parameter int    WIDTH0 = 8,
    parameter int    WIDTH1 = 8,
    parameter string BURST  = BURST_YES
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iValid_AM0,
    output logic                     oReady_AM0,
    input  logic [WIDTH0-1:0]        iData_AM0,
    input  logic                     iValid_AM1,
    output logic                     oReady_AM1,
    input  logic [WIDTH1-1:0]        iData_AM1,
    output logic                     oValid_BM,
    input  logic                     iReady_BM,
    output logic [WIDTH0+WIDTH1-1:0] oData_BM
);

    logic              full0;
    logic              full1;
    logic [WIDTH0-1:0] slot0;
    logic [WIDTH1-1:0] slot1;
    logic              fire;

    assign oValid_BM = full0 & full1;
    assign fire      = oValid_BM & iReady_BM;
    assign oData_BM  = {slot1, slot0};

    stream_slot #(.WIDTH(WIDTH0), .BURST(BURST)) u_slot0 (
        .clk   (iCLK),
        .rst_n (iRST),
        .valid (iValid_AM0),
        .data  (iData_AM0),
        .drain (fire),
        .full  (full0),
        .q     (slot0),
        .ready (oReady_AM0)
    );

    stream_slot #(.WIDTH(WIDTH1), .BURST(BURST)) u_slot1 (
        .clk   (iCLK),
        .rst_n (iRST),
        .valid (iValid_AM1),
        .data  (iData_AM1),
        .drain (fire),
        .full  (full1),
        .q     (slot1),
        .ready (oReady_AM1)
    );

`ifdef STREAM_COMBINER_ASSERT_EN
    logic                     chk_vld_q;
    logic                     chk_rdy_q;
    logic [WIDTH0+WIDTH1-1:0] chk_data_q;

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            chk_vld_q  <= 1'b0;
            chk_rdy_q  <= 1'b0;
            chk_data_q <= '0;
        end else begin
            if ($isunknown(oValid_BM))
                $error("stream_combiner: oValid_BM is X/Z");
            if (chk_vld_q && !chk_rdy_q && oData_BM != chk_data_q)
                $error("stream_combiner: oData_BM changed under backpressure");
            if (chk_vld_q && !chk_rdy_q && !oValid_BM)
                $error("stream_combiner: oValid_BM dropped without a transfer");
            chk_vld_q  <= oValid_BM;
            chk_rdy_q  <= iReady_BM;
            chk_data_q <= oData_BM;
        end
    end
`endif

endmodule

// File: tb/tb_stream_combiner.sv
// Bench for stream_combiner: a BURST="yes" and a BURST="no" instance, each
// checked every cycle against a beat-level model of the join.
module tb_stream_combiner;

    logic       clk;
    logic       rst_n;
    logic       v0  [2];
    logic       v1  [2];
    logic [3:0] d0  [2];
    logic [3:0] d1  [2];
    logic       rdy [2];
    logic       r0  [2];
    logic       r1  [2];
    logic       ov  [2];
    logic [7:0] od  [2];

    int checks = 0;
    int errors = 0;

    // model: pending beat per lane
    bit       mf0 [2];
    bit       mf1 [2];
    bit [3:0] md0 [2];
    bit [3:0] md1 [2];
    bit       acc0 [2];
    bit       acc1 [2];
    int       nout [2];

    stream_combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dut_yes (
        .iCLK(clk), .iRST(rst_n),
        .iValid_AM0(v0[0]), .oReady_AM0(r0[0]), .iData_AM0(d0[0]),
        .iValid_AM1(v1[0]), .oReady_AM1(r1[0]), .iData_AM1(d1[0]),
        .oValid_BM(ov[0]), .iReady_BM(rdy[0]), .oData_BM(od[0])
    );

    stream_combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dut_no (
        .iCLK(clk), .iRST(rst_n),
        .iValid_AM0(v0[1]), .oReady_AM0(r0[1]), .iData_AM0(d0[1]),
        .iValid_AM1(v1[1]), .oReady_AM1(r1[1]), .iData_AM1(d1[1]),
        .oValid_BM(ov[1]), .iReady_BM(rdy[1]), .oData_BM(od[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed no finish required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mf0[k] = 0; mf1[k] = 0; md0[k] = 0; md1[k] = 0;
        end
    endtask

    task automatic drive_both(input logic a0, input logic [3:0] x0,
                              input logic a1, input logic [3:0] x1, input logic rb);
        for (int k = 0; k < 2; k++) begin
            v0[k] = a0; d0[k] = x0; v1[k] = a1; d1[k] = x1; rdy[k] = rb;
        end
    endtask

    // Compare both DUTs to the model mid-cycle, then advance the model one edge.
    task automatic step();
        bit fire, er0, er1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            fire = mf0[k] && mf1[k] && rdy[k];
            er0  = !mf0[k] || (k == 0 && fire);
            er1  = !mf1[k] || (k == 0 && fire);
            chk("valid", k, {31'd0, ov[k]}, {31'd0, mf0[k] & mf1[k]});
            chk("data",  k, {24'd0, od[k]}, {24'd0, md1[k], md0[k]});
            chk("ready0", k, {31'd0, r0[k]}, {31'd0, er0});
            chk("ready1", k, {31'd0, r1[k]}, {31'd0, er1});
            if (ov[k] === 1'b1 && rdy[k]) nout[k]++;
            acc0[k] = v0[k] && er0;
            acc1[k] = v1[k] && er1;
            if (fire) begin mf0[k] = 0; mf1[k] = 0; end
            if (acc0[k]) begin mf0[k] = 1; md0[k] = d0[k]; end
            if (acc1[k]) begin mf1[k] = 1; md1[k] = d1[k]; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, {31'd0, ov[k]}, 32'd0);
            chk("arst_r0", k, {31'd0, r0[k]}, 32'd1);
            chk("arst_r1", k, {31'd0, r1[k]}, 32'd1);
            chk("arst_data", k, {24'd0, od[k]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [3:0] c0 [2];
        bit [3:0] c1 [2];
        rst_n = 1'b0;
        drive_both(0, 4'h0, 0, 4'h0, 1);
        model_clear();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, {31'd0, ov[k]}, 32'd0);
            chk("rst_data", k, {24'd0, od[k]}, 32'h00);
            chk("rst_r0", k, {31'd0, r0[k]}, 32'd1);
            chk("rst_r1", k, {31'd0, r1[k]}, 32'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) step();

        // staggered arrival
        drive_both(1, 4'ha, 0, 4'h0, 1); step();
        drive_both(0, 4'h0, 1, 4'hb, 1); step();
        drive_both(0, 4'h0, 0, 4'h0, 1);
        for (int k = 0; k < 2; k++) begin
            chk("stag_valid", k, {31'd0, ov[k]}, 32'd1);
            chk("stag_data", k, {24'd0, od[k]}, 32'hba);
        end
        step();
        for (int k = 0; k < 2; k++) chk("stag_done", k, {31'd0, ov[k]}, 32'd0);
        step();

        // backpressure
        drive_both(1, 4'h7, 0, 4'h0, 0);
        repeat (4) step();
        for (int k = 0; k < 2; k++) chk("bp_r0_low", k, {31'd0, r0[k]}, 32'd0);
        drive_both(0, 4'h0, 1, 4'h8, 0); step();
        drive_both(0, 4'h0, 0, 4'h0, 0);
        for (int k = 0; k < 2; k++) chk("bp_data", k, {24'd0, od[k]}, 32'h87);
        repeat (3) step();
        for (int k = 0; k < 2; k++) chk("bp_held", k, {24'd0, od[k]}, 32'h87);
        drive_both(0, 4'h0, 0, 4'h0, 1); step();
        step();

        // simultaneous arrival
        drive_both(1, 4'h3, 1, 4'h5, 1); step();
        drive_both(0, 4'h0, 0, 4'h0, 1);
        for (int k = 0; k < 2; k++) chk("simul_data", k, {ov[k], 23'd0, od[k]}, {1'b1, 23'd0, 8'h53});
        repeat (2) step();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                v0[k]  = 1'($urandom_range(0, 1));
                v1[k]  = 1'($urandom_range(0, 1));
                d0[k]  = 4'($urandom);
                d1[k]  = 4'($urandom);
                rdy[k] = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        // async reset with one lane holding a beat
        drive_both(1, 4'he, 0, 4'h0, 0);
        async_reset_pulse();
        drive_both(0, 4'h0, 0, 4'h0, 1);
        async_reset_pulse();
        drive_both(1, 4'hc, 0, 4'h0, 1); step();
        drive_both(0, 4'h0, 0, 4'h0, 1);
        async_reset_pulse();
        drive_both(0, 4'h0, 1, 4'h2, 1); step();
        drive_both(0, 4'h0, 0, 4'h0, 1);
        for (int k = 0; k < 2; k++) chk("arst_drop", k, {31'd0, ov[k]}, 32'd0);
        repeat (2) step();
        async_reset_pulse();

        // streaming throughput
        for (int k = 0; k < 2; k++) begin
            nout[k] = 0; c0[k] = 0; c1[k] = 0;
            v0[k] = 1; v1[k] = 1; rdy[k] = 1;
        end
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 2; k++) begin
                d0[k] = c0[k]; d1[k] = c1[k];
            end
            step();
            for (int k = 0; k < 2; k++) begin
                if (acc0[k]) c0[k]++;
                if (acc1[k]) c1[k]++;
            end
        end
        chk("tput_yes", 0, nout[0], 32'd19);
        chk("tput_no", 1, nout[1], 32'd10);
        drive_both(0, 4'h0, 0, 4'h0, 1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
